// File: rtl/rv32m_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional macro RV32M_DIV_FASTPATH_EN: divide-by-zero and signed overflow complete in one cycle.
//   state | meaning
//   IDLE  | waiting for start; operands latched on start
//   CALC  | one quotient bit per cycle, XLEN cycles
//   FIX   | sign correction, result/rd_out registered
//   DONE  | done/wb_we pulse
module rv32m_div_unit #(
  parameter int XLEN  = 32,
  parameter int index = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [index-1:0] rd_in,
  output logic             busy,
  output logic             done,
  output logic             wb_we,
  output logic [index-1:0] rd_out,
  output logic [XLEN-1:0]  result
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic             sel_rem, q_neg, r_neg, div0_q;
  logic [index-1:0] rd_q;
  logic [XLEN-1:0]  rem, quo, dvs;
  logic [CW-1:0]    count;

  logic            is_signed, s1, s2, div0_in, fast;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign is_signed = ~op[0];
  assign s1        = is_signed & rs1_val[XLEN-1];
  assign s2        = is_signed & rs2_val[XLEN-1];
  assign abs1      = s1 ? (~rs1_val + 1'b1) : rs1_val;
  assign abs2      = s2 ? (~rs2_val + 1'b1) : rs2_val;
  assign div0_in   = (rs2_val == '0);

`ifdef RV32M_DIV_FASTPATH_EN
  logic ovf_in;
  assign ovf_in = is_signed && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
  assign fast   = div0_in | ovf_in;
`else
  assign fast   = 1'b0;
`endif

  assign rem_sh = {rem, quo[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign ge     = ~diff[XLEN];

  // The iterative quotient for x/0 is all ones before sign fix; force it so signed x/0 stays all ones.
  assign quo_fix = div0_q ? '1 : (q_neg ? (~quo + 1'b1) : quo);
  assign rem_fix = r_neg ? (~rem + 1'b1) : rem;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    wb_we     = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = fast ? DONE : CALC;
      CALC:    if (count == CW'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sel_rem <= 1'b0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      div0_q  <= 1'b0;
      rd_q    <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      count   <= '0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sel_rem <= op[1];
          q_neg   <= s1 ^ s2;
          r_neg   <= s1;
          div0_q  <= div0_in;
          rd_q    <= rd_in;
          rem     <= '0;
          quo     <= abs1;
          dvs     <= abs2;
          count   <= CW'(XLEN);
`ifdef RV32M_DIV_FASTPATH_EN
          if (fast) begin
            if (div0_in) result <= op[1] ? rs1_val : '1;
            else         result <= op[1] ? '0 : rs1_val;
            rd_out <= rd_in;
          end
`endif
        end
        CALC: begin
          rem   <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
          quo   <= {quo[XLEN-2:0], ge};
          count <= count - 1'b1;
        end
        FIX: begin
          result <= sel_rem ? rem_fix : quo_fix;
          rd_out <= rd_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_div_unit.sv
// Directed self-checking bench for rv32m_div_unit; latency of special cases depends on RV32M_DIV_FASTPATH_EN.
module tb_rv32m_div_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs1_val = '0, rs2_val = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, wb_we;
  logic [4:0]  rd_out;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

`ifdef RV32M_DIV_FASTPATH_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 34;
`endif

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  rv32m_div_unit dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in),
    .busy(busy), .done(done), .wb_we(wb_we), .rd_out(rd_out), .result(result)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; start is high through the edge that ends cycle 0.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int n;
    op = o; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
    n = 0;
    while (n < 100) begin
      @(posedge CLK); #1;
      n++;
      if (n == 1) begin
        start = 1'b0; rs1_val = ~a; rs2_val = b + 32'd3; rd_in = ~rd;
      end
      if (done) break;
    end
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " wb_we"}, {31'b0, wb_we}, 32'd1);
    chk({tag, " result"}, result, exp);
    chk({tag, " rd_out"}, {27'b0, rd_out}, {27'b0, rd});
    @(posedge CLK); #1;
    chk({tag, " done cleared"}, {31'b0, done}, 32'd0);
    chk({tag, " busy cleared"}, {31'b0, busy}, 32'd0);
    chk({tag, " result held"}, result, exp);
  endtask

  initial begin
    int ndone, first_c, second_c;
    #12;
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset wb_we", {31'b0, wb_we}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rd_out", {27'b0, rd_out}, 32'd0);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;

    run_op("div 100/7", DIV, 32'd100, 32'd7, 5'd5, 32'd14, 34);
    run_op("rem -100/7", REM, 32'hFFFFFF9C, 32'd7, 5'd6, 32'hFFFFFFFE, 34);
    run_op("div -100/7", DIV, 32'hFFFFFF9C, 32'd7, 5'd7, 32'hFFFFFFF2, 34);
    run_op("remu 100/7", REMU, 32'd100, 32'd7, 5'd8, 32'd2, 34);
    run_op("divu x/0", DIVU, 32'hFFFFFFFF, 32'd0, 5'd9, 32'hFFFFFFFF, SPECIAL_LAT);
    run_op("remu x/0", REMU, 32'hFFFFFFFF, 32'd0, 5'd10, 32'hFFFFFFFF, SPECIAL_LAT);
    run_op("div -7/0", DIV, 32'hFFFFFFF9, 32'd0, 5'd11, 32'hFFFFFFFF, SPECIAL_LAT);
    run_op("rem -7/0", REM, 32'hFFFFFFF9, 32'd0, 5'd12, 32'hFFFFFFF9, SPECIAL_LAT);
    run_op("div ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, SPECIAL_LAT);
    run_op("rem ovf", REM, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0, SPECIAL_LAT);
    run_op("divu big", DIVU, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0, 34);

    // start held high: second request accepted only after IDLE is reached
    op = DIVU; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd3; start = 1'b1;
    ndone = 0; first_c = 0; second_c = 0;
    for (int c = 1; c <= 69; c++) begin
      @(posedge CLK); #1;
      if (done) begin
        ndone++;
        if (ndone == 1) first_c = c;
        else second_c = c;
      end
    end
    start = 1'b0;
    chk("hold done count", ndone, 32'd2);
    chk("hold first done", first_c, 32'd34);
    chk("hold second done", second_c, 32'd69);
    chk("hold result", result, 32'd14);
    @(posedge CLK); #1;
    chk("hold idle after", {31'b0, busy}, 32'd0);

    // reset in cycle 10 of a DIVU
    op = DIVU; rs1_val = 32'd5000; rs2_val = 32'd3; rd_in = 5'd9; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (9) begin @(posedge CLK); #1; end
    chk("abort busy before", {31'b0, busy}, 32'd1);
    RST = 1'b1;
    #1;
    chk("abort busy", {31'b0, busy}, 32'd0);
    chk("abort result", result, 32'd0);
    chk("abort rd_out", {27'b0, rd_out}, 32'd0);
    chk("abort done", {31'b0, done}, 32'd0);
    @(negedge CLK); RST = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (done) ndone++;
    end
    chk("abort no done", ndone, 32'd0);
    run_op("divu after reset", DIVU, 32'd1000, 32'd10, 5'd17, 32'd100, 34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
